systolic_matmul_stream: RTL

SYSTOLIC_MATMUL_STREAM -- requirements
Module: systolic_matmul_stream

---
 rtl/systolic_pkg.sv | 37 +++
 rtl/systolic_pe.sv | 96 +++++++++
 rtl/systolic_matmul_stream.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared definitions for the streaming systolic matrix
//               multiplier: controller state encoding, run-length helper
//               and parameter-legality predicates.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Cycles for the last operand pair to reach PE(N-1,N-1): the skewed
    // wavefront spans 2(N-1) diagonals plus N reduction steps.
    function automatic int MULT_CYCLES(input int n);
        return 3 * n - 2;
    endfunction

    function automatic bit n_is_legal(input int n);
        return (n >= 3) && (n <= 256);
    endfunction

    function automatic bit data_w_is_legal(input int dw);
        return (dw >= 2) && (dw <= 16);
    endfunction

    // Accumulator must hold N full-width products without loss.
    function automatic bit acc_w_is_legal(input int n, input int dw, input int aw);
        return aw >= (2 * dw + $clog2(n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pe.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pe
// Description : One multiply-accumulate cell of the output-stationary array.
//               Multiplies the operand pair presented this cycle and adds the
//               product into a local accumulator.
// Ports       : i_clk, i_srst  - clock / synchronous active-high reset
//               i_clear        - zero the accumulator (start of a fresh tile)
//               i_en           - accumulate this cycle; otherwise hold
//               i_signed       - operands are two's complement when 1
//               i_a, i_b       - operand pair
//               o_acc          - accumulator contents
// Options     : SYSTOLIC_SATURATE_EN - clamp the accumulator at the signed or
//               unsigned ACC_W limits instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_srst,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_acc
);

    // Two extra bits keep the exact product of two sign-extended operands
    // representable as a signed value in either mode.
    localparam int c_prod_w = 2 * DATA_W + 2;

    logic [c_prod_w-1:0] w_a_x;
    logic [c_prod_w-1:0] w_b_x;
    logic [c_prod_w-1:0] w_prod;
    logic [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W-1:0]    w_acc_next;
    logic [ACC_W-1:0]    r_acc;

    assign w_a_x  = {{(DATA_W + 2){i_signed & i_a[DATA_W-1]}}, i_a};
    assign w_b_x  = {{(DATA_W + 2){i_signed & i_b[DATA_W-1]}}, i_b};
    assign w_prod = w_a_x * w_b_x;

    // In unsigned mode the product MSB is always 0, so this is a zero-extend.
    generate
        if (ACC_W > c_prod_w) begin : g_prod_ext
            assign w_prod_ext = {{(ACC_W - c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
        end else begin : g_prod_fit
            assign w_prod_ext = w_prod[ACC_W-1:0];
        end
    endgenerate

`ifdef SYSTOLIC_SATURATE_EN
    logic [ACC_W:0]   w_usum;
    logic [ACC_W-1:0] w_wsum;
    logic             w_sovf;

    assign w_usum = {1'b0, r_acc} + {1'b0, w_prod_ext};
    assign w_wsum = w_usum[ACC_W-1:0];
    // Signed overflow: like-signed addends producing a differently-signed sum.
    assign w_sovf = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                    (w_wsum[ACC_W-1] != r_acc[ACC_W-1]);

    always_comb begin
        w_acc_next = w_wsum;
        if (i_signed) begin
            if (w_sovf) begin
                w_acc_next = r_acc[ACC_W-1] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                            : {1'b0, {(ACC_W - 1){1'b1}}};
            end
        end else if (w_usum[ACC_W]) begin
            w_acc_next = {ACC_W{1'b1}};
        end
    end
`else
    assign w_acc_next = r_acc + w_prod_ext;
`endif

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_acc_next;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/systolic_matmul_stream.sv
`default_nettype none
// ============================================================================
// Module      : systolic_matmul_stream
// Description : Streaming N x N tile matrix multiplier, C = A*B (or C += A*B),
//               built on an output-stationary N x N array of systolic_pe.
//               A rows enter from the west and B columns from the north, each
//               skewed so that A[i][k] meets B[k][j] in PE(i,j) on one cycle.
// Ports       : i_clk, i_srst          - clock / synchronous active-high reset
//               i_a, i_b               - operand tiles, row-major
//               i_signed, i_accumulate - mode, sampled at accept
//               i_valid / o_ready      - input handshake (ready only in IDLE)
//               o_c / o_valid, i_ready - result handshake (valid in DONE)
//               o_busy                 - controller not in IDLE
// Options     : SYSTOLIC_SATURATE_EN - saturating accumulators (in systolic_pe)
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_matmul_stream
    import systolic_pkg::*;
#(
    parameter int N      = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                             i_clk,
    input  logic                             i_srst,
    input  logic [N-1:0][N-1:0][DATA_W-1:0]  i_a,
    input  logic [N-1:0][N-1:0][DATA_W-1:0]  i_b,
    input  logic                             i_signed,
    input  logic                             i_accumulate,
    input  logic                             i_valid,
    output logic                             o_ready,
    output logic [N-1:0][N-1:0][ACC_W-1:0]   o_c,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic                             o_busy
);

    localparam int c_run_cycles = MULT_CYCLES(N);
    localparam int c_skew_len   = 2 * N - 1;
    localparam int c_cnt_w      = $clog2(c_run_cycles);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_run_cycles - 1);

    generate
        if (!n_is_legal(N)) begin : g_bad_n
            $error("systolic_matmul_stream: N must lie in 3..256");
        end
        if (!data_w_is_legal(DATA_W)) begin : g_bad_data_w
            $error("systolic_matmul_stream: DATA_W must lie in 2..16");
        end
        if (!acc_w_is_legal(N, DATA_W, ACC_W)) begin : g_bad_acc_w
            $error("systolic_matmul_stream: ACC_W must be >= 2*DATA_W+clog2(N)");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_run;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_signed;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_run        = 1'b0;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        o_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (i_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
                if (r_cnt == c_cnt_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_cnt    <= '0;
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_signed <= i_signed;
        end else if (w_run) begin
            r_cnt    <= r_cnt + c_cnt_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // Skew feeders: row i of A (column j of B) is loaded pre-shifted by i
    // (j) zero slots and drained one element per RUN cycle from slot 0.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_a_ld [N][c_skew_len];
    logic [DATA_W-1:0] w_b_ld [N][c_skew_len];
    logic [DATA_W-1:0] r_a_sk [N][c_skew_len];
    logic [DATA_W-1:0] r_b_sk [N][c_skew_len];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_skew_lane
            for (genvar gk = 0; gk < c_skew_len; gk++) begin : g_tap
                if ((gk >= gi) && (gk < gi + N)) begin : g_data
                    assign w_a_ld[gi][gk] = i_a[gi][gk-gi];
                    assign w_b_ld[gi][gk] = i_b[gk-gi][gi];
                end else begin : g_zero
                    assign w_a_ld[gi][gk] = '0;
                    assign w_b_ld[gi][gk] = '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < c_skew_len; k++) begin
                    r_a_sk[i][k] <= '0;
                    r_b_sk[i][k] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < c_skew_len; k++) begin
                    r_a_sk[i][k] <= w_a_ld[i][k];
                    r_b_sk[i][k] <= w_b_ld[i][k];
                end
            end
        end else if (w_run) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < c_skew_len - 1; k++) begin
                    r_a_sk[i][k] <= r_a_sk[i][k+1];
                    r_b_sk[i][k] <= r_b_sk[i][k+1];
                end
                r_a_sk[i][c_skew_len-1] <= '0;
                r_b_sk[i][c_skew_len-1] <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // PE array: operands hop one PE east (A) / south (B) per RUN cycle.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_a_in [N][N];
    logic [DATA_W-1:0] w_b_in [N][N];
    logic [DATA_W-1:0] r_a_p  [N][N-1];
    logic [DATA_W-1:0] r_b_p  [N-1][N];

    always_ff @(posedge i_clk) begin
        if (i_srst || w_accept) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N - 1; j++) begin
                    r_a_p[i][j] <= '0;
                    r_b_p[j][i] <= '0;
                end
            end
        end else if (w_run) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N - 1; j++) begin
                    r_a_p[i][j] <= w_a_in[i][j];
                    r_b_p[j][i] <= w_b_in[j][i];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pe_row
            for (genvar gj = 0; gj < N; gj++) begin : g_pe_col
                if (gj == 0) begin : g_a_edge
                    assign w_a_in[gi][gj] = r_a_sk[gi][0];
                end else begin : g_a_inner
                    assign w_a_in[gi][gj] = r_a_p[gi][gj-1];
                end
                if (gi == 0) begin : g_b_edge
                    assign w_b_in[gi][gj] = r_b_sk[gj][0];
                end else begin : g_b_inner
                    assign w_b_in[gi][gj] = r_b_p[gi-1][gj];
                end

                systolic_pe #(
                    .DATA_W (DATA_W),
                    .ACC_W  (ACC_W)
                ) u_pe (
                    .i_clk    (i_clk),
                    .i_srst   (i_srst),
                    .i_clear  (w_accept & ~i_accumulate),
                    .i_en     (w_run),
                    .i_signed (r_signed),
                    .i_a      (w_a_in[gi][gj]),
                    .i_b      (w_b_in[gi][gj]),
                    .o_acc    (o_c[gi][gj])
                );
            end
        end
    endgenerate

endmodule
`default_nettype wire
